// File: rtl/z80_sysctrl.sv
// z80_sysctrl: sound-side system controller for the Z80.
// Decodes the Z80 I/O bus into the 68k<->Z80 mailbox, NMI request logic,
// the four ROM bank registers and the YM2610 select. Also produces the
// banked ROM address and the ROM/RAM selects from the memory bus.
// Single clock domain (CLK_4M), synchronous active-low reset.

module z80_sysctrl (
  input  logic        CLK_4M,
  input  logic        nRESET,
  input  logic [15:0] SDA,
  input  logic [7:0]  SDD_OUT,
  input  logic        nIORQ,
  input  logic        nMREQ,
  input  logic        nRD,
  input  logic        nWR,
  input  logic        CMD_WR,
  input  logic [7:0]  CMD_DATA,
  output logic [7:0]  REPLY,
  output logic [7:0]  IO_DIN,
  output logic        nNMI,
  output logic        NMI_EN,
  output logic [21:0] ROM_ADDR,
  output logic        nROM_CS,
  output logic        nRAM_CS,
  output logic        nYM_CS,
  output logic [1:0]  YM_A
);

  // I/O port numbers; only SDA[4:0] are decoded, so SDA[7:5] mirror.
  localparam logic [4:0] PORT_CMD     = 5'h00;
  localparam logic [4:0] PORT_NMI_ON  = 5'h08;
  localparam logic [4:0] PORT_NMI_OFF = 5'h18;
  localparam logic [4:0] PORT_REPLY   = 5'h0C;
  localparam logic [4:0] PORT_BANK2K  = 5'h08;
  localparam logic [4:0] PORT_BANK4K  = 5'h09;
  localparam logic [4:0] PORT_BANK8K  = 5'h0A;
  localparam logic [4:0] PORT_BANK16K = 5'h0B;

  // Bank reset values give an identity map of the upper 32 KiB.
  localparam logic [7:0] BANK16K_RST = 8'h02;
  localparam logic [7:0] BANK8K_RST  = 8'h06;
  localparam logic [7:0] BANK4K_RST  = 8'h0E;
  localparam logic [7:0] BANK2K_RST  = 8'h1E;

  // Strobe decode and edge detection.
  logic       w_io_rd;
  logic       w_io_wr;
  logic       r_io_rd_prev;
  logic       r_io_wr_prev;
  logic       w_rd_edge;
  logic       w_wr_edge;
  logic [4:0] w_port;
  logic       w_clr_pend;

  // Architectural state.
  logic [7:0] r_cmd_latch;
  logic [7:0] r_reply;
  logic       r_nmi_pend;
  logic       r_nmi_en;
  logic       r_nnmi;
  logic [7:0] r_bank16k;
  logic [7:0] r_bank8k;
  logic [7:0] r_bank4k;
  logic [7:0] r_bank2k;

  // Combinational helpers.
  logic [7:0]  w_io_din;
  logic        w_ym_sel;
  logic        w_ram_region;
  logic [21:0] w_rom_addr;

  assign w_io_rd = ~nIORQ & ~nRD;
  assign w_io_wr = ~nIORQ & ~nWR;
  assign w_port  = SDA[4:0];

  // An access acts only on its first low cycle.
  assign w_rd_edge = w_io_rd & ~r_io_rd_prev;
  assign w_wr_edge = w_io_wr & ~r_io_wr_prev;

  // Either a read or a write of the command port acknowledges the NMI.
  assign w_clr_pend = (w_rd_edge | w_wr_edge) & (w_port == PORT_CMD);

  // Previous-cycle strobe history; it keeps tracking during reset so a
  // strobe that is already low at reset release is not seen as a new access.
  always_ff @(posedge CLK_4M) begin
    r_io_rd_prev <= w_io_rd;
    r_io_wr_prev <= w_io_wr;
  end

  // Command latch and NMI pending flag; a new command beats an acknowledge.
  always_ff @(posedge CLK_4M) begin
    if (!nRESET) begin
      r_cmd_latch <= 8'h00;
      r_nmi_pend  <= 1'b0;
    end else if (CMD_WR) begin
      r_cmd_latch <= CMD_DATA;
      r_nmi_pend  <= 1'b1;
    end else if (w_clr_pend) begin
      r_nmi_pend  <= 1'b0;
    end
  end

  // NMI enable, set and cleared by writes to the two control ports.
  always_ff @(posedge CLK_4M) begin
    if (!nRESET) begin
      r_nmi_en <= 1'b0;
    end else if (w_wr_edge && (w_port == PORT_NMI_ON)) begin
      r_nmi_en <= 1'b1;
    end else if (w_wr_edge && (w_port == PORT_NMI_OFF)) begin
      r_nmi_en <= 1'b0;
    end
  end

  // Registered NMI output: one cycle behind the pending/enable state.
  always_ff @(posedge CLK_4M) begin
    if (!nRESET) begin
      r_nnmi <= 1'b1;
    end else begin
      r_nnmi <= ~(r_nmi_pend & r_nmi_en);
    end
  end

  // Reply byte returned to the 68k side.
  always_ff @(posedge CLK_4M) begin
    if (!nRESET) begin
      r_reply <= 8'h00;
    end else if (w_wr_edge && (w_port == PORT_REPLY)) begin
      r_reply <= SDD_OUT;
    end
  end

  // ROM bank registers, loaded from the upper address byte of an I/O read.
  always_ff @(posedge CLK_4M) begin
    if (!nRESET) begin
      r_bank16k <= BANK16K_RST;
      r_bank8k  <= BANK8K_RST;
      r_bank4k  <= BANK4K_RST;
      r_bank2k  <= BANK2K_RST;
    end else if (w_rd_edge) begin
      case (w_port)
        PORT_BANK2K:  r_bank2k  <= SDA[15:8];
        PORT_BANK4K:  r_bank4k  <= SDA[15:8];
        PORT_BANK8K:  r_bank8k  <= SDA[15:8];
        PORT_BANK16K: r_bank16k <= SDA[15:8];
        default:      r_bank2k  <= r_bank2k;
      endcase
    end
  end

  // I/O read data: the command latch on port 0, open bus elsewhere.
  always_comb begin
    w_io_din = 8'hFF;
    if (w_port == PORT_CMD) begin
      w_io_din = r_cmd_latch;
    end else begin
      w_io_din = 8'hFF;
    end
  end

  // YM2610 occupies ports 4..7 and is selected while the strobe is low.
  assign w_ym_sel = (w_port[4:2] == 3'b001) & (w_io_rd | w_io_wr);

  // Banked ROM address; windows shrink by half towards the top of memory.
  always_comb begin
    w_rom_addr   = {11'b0, SDA[10:0]};
    w_ram_region = 1'b0;
    casez (SDA[15:11])
      5'b0????: w_rom_addr = {7'b0, SDA[14:0]};
      5'b10???: w_rom_addr = {r_bank16k, SDA[13:0]};
      5'b110??: w_rom_addr = {1'b0, r_bank8k, SDA[12:0]};
      5'b1110?: w_rom_addr = {2'b0, r_bank4k, SDA[11:0]};
      5'b11110: w_rom_addr = {3'b0, r_bank2k, SDA[10:0]};
      5'b11111: begin
        w_rom_addr   = {11'b0, SDA[10:0]};
        w_ram_region = 1'b1;
      end
      default: begin
        w_rom_addr   = {11'b0, SDA[10:0]};
        w_ram_region = 1'b0;
      end
    endcase
  end

  assign REPLY    = r_reply;
  assign IO_DIN   = w_io_din;
  assign nNMI     = r_nnmi;
  assign NMI_EN   = r_nmi_en;
  assign ROM_ADDR = w_rom_addr;
  assign nROM_CS  = ~(~nMREQ & ~w_ram_region);
  assign nRAM_CS  = ~(~nMREQ & w_ram_region);
  assign nYM_CS   = ~w_ym_sel;
  assign YM_A     = SDA[1:0];

endmodule

// File: tb/tb_z80_sysctrl.sv
// Directed self-checking bench for z80_sysctrl.

module tb_z80_sysctrl;

  logic        CLK_4M = 1'b0;
  logic        nRESET;
  logic [15:0] SDA;
  logic [7:0]  SDD_OUT;
  logic        nIORQ, nMREQ, nRD, nWR;
  logic        CMD_WR;
  logic [7:0]  CMD_DATA;
  logic [7:0]  REPLY;
  logic [7:0]  IO_DIN;
  logic        nNMI;
  logic        NMI_EN;
  logic [21:0] ROM_ADDR;
  logic        nROM_CS, nRAM_CS, nYM_CS;
  logic [1:0]  YM_A;

  int n_checks = 0;
  int n_errors = 0;

  z80_sysctrl dut (
    .CLK_4M   (CLK_4M),
    .nRESET   (nRESET),
    .SDA      (SDA),
    .SDD_OUT  (SDD_OUT),
    .nIORQ    (nIORQ),
    .nMREQ    (nMREQ),
    .nRD      (nRD),
    .nWR      (nWR),
    .CMD_WR   (CMD_WR),
    .CMD_DATA (CMD_DATA),
    .REPLY    (REPLY),
    .IO_DIN   (IO_DIN),
    .nNMI     (nNMI),
    .NMI_EN   (NMI_EN),
    .ROM_ADDR (ROM_ADDR),
    .nROM_CS  (nROM_CS),
    .nRAM_CS  (nRAM_CS),
    .nYM_CS   (nYM_CS),
    .YM_A     (YM_A)
  );

  // 4 MHz-style free-running clock.
  always #5 CLK_4M = ~CLK_4M;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_4M);
    #1;
  endtask

  task automatic bus_idle();
    nIORQ = 1'b1; nMREQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
  endtask

  task automatic io_rd_start(input logic [15:0] a);
    SDA = a; nIORQ = 1'b0; nRD = 1'b0;
    #1;
  endtask

  task automatic io_wr_start(input logic [15:0] a, input logic [7:0] d);
    SDA = a; SDD_OUT = d; nIORQ = 1'b0; nWR = 1'b0;
    #1;
  endtask

  // Complete I/O access held for cyc cycles, then one idle cycle.
  task automatic io_access(input logic [15:0] a, input logic [7:0] d, input logic wr, input int cyc);
    if (wr) io_wr_start(a, d);
    else    io_rd_start(a);
    repeat (cyc) tick();
    bus_idle();
    tick();
  endtask

  task automatic mem_check(input string tag, input logic [15:0] a, input logic [21:0] exp_addr,
                           input logic exp_rom, input logic exp_ram);
    SDA = a; nMREQ = 1'b0; nRD = 1'b0;
    #1;
    check_val({tag, "_addr"}, 32'(ROM_ADDR), 32'(exp_addr));
    check_val({tag, "_romcs"}, 32'(nROM_CS), 32'(exp_rom));
    check_val({tag, "_ramcs"}, 32'(nRAM_CS), 32'(exp_ram));
    nMREQ = 1'b1; nRD = 1'b1;
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] d);
    CMD_DATA = d; CMD_WR = 1'b1;
    tick();
    CMD_WR = 1'b0;
  endtask

  initial begin
    bus_idle();
    SDA = 16'h0000; SDD_OUT = 8'h00; CMD_WR = 1'b0; CMD_DATA = 8'h00;
    nRESET = 1'b0;
    repeat (3) tick();

    // Reset state
    check_val("rst_reply", 32'(REPLY), 32'h00);
    check_val("rst_nmien", 32'(NMI_EN), 32'h0);
    check_val("rst_nnmi", 32'(nNMI), 32'h1);
    check_val("rst_iodin", 32'(IO_DIN), 32'h00);
    check_val("rst_ymcs", 32'(nYM_CS), 32'h1);
    check_val("idle_romcs", 32'(nROM_CS), 32'h1);
    check_val("idle_ramcs", 32'(nRAM_CS), 32'h1);
    nRESET = 1'b1;
    tick();

    // Linear map at reset
    mem_check("m0000", 16'h1234, 22'h001234, 1'b0, 1'b1);
    mem_check("m8000", 16'h8000, 22'h008000, 1'b0, 1'b1);
    mem_check("mC123", 16'hC123, 22'h00C123, 1'b0, 1'b1);
    mem_check("mE456", 16'hE456, 22'h00E456, 1'b0, 1'b1);
    mem_check("mF789", 16'hF789, 22'h00F789, 1'b0, 1'b1);
    mem_check("mF800", 16'hF800, 22'h000000, 1'b1, 1'b0);
    mem_check("mFFFF", 16'hFFFF, 22'h0007FF, 1'b1, 1'b0);
    tick();

    // Bank loads
    io_rd_start(16'h350B);
    check_val("iodin_ff", 32'(IO_DIN), 32'hFF);
    tick(); bus_idle(); tick();
    mem_check("m8001", 16'h8001, 22'h0D4001, 1'b0, 1'b1);
    io_access(16'h7F08, 8'h00, 1'b0, 1);
    mem_check("mF010", 16'hF010, 22'h03F810, 1'b0, 1'b1);
    io_access(16'h012A, 8'h00, 1'b0, 1);   // mirrored port $0A -> bank8k=01
    mem_check("mC123b", 16'hC123, 22'h002123, 1'b0, 1'b1);
    tick();

    // NMI enabled, command delivery and acknowledge
    io_access(16'h0008, 8'h00, 1'b1, 1);
    check_val("nmien_on", 32'(NMI_EN), 32'h1);
    check_val("nnmi_idle", 32'(nNMI), 32'h1);
    send_cmd(8'hA5);
    check_val("nnmi_c1", 32'(nNMI), 32'h1);
    tick();
    check_val("nnmi_c2", 32'(nNMI), 32'h0);
    io_rd_start(16'h0000);
    check_val("rd00_a5", 32'(IO_DIN), 32'hA5);
    tick();
    check_val("ack_c1", 32'(nNMI), 32'h0);
    tick();
    check_val("ack_c2", 32'(nNMI), 32'h1);
    bus_idle(); tick();

    // Pending while disabled
    io_access(16'h0018, 8'h00, 1'b1, 1);
    check_val("nmien_off", 32'(NMI_EN), 32'h0);
    send_cmd(8'h11);
    repeat (3) tick();
    check_val("dis_nnmi", 32'(nNMI), 32'h1);
    io_wr_start(16'h0008, 8'h00);
    tick();
    check_val("en_nmien", 32'(NMI_EN), 32'h1);
    check_val("en_c1", 32'(nNMI), 32'h1);
    tick();
    check_val("en_c2", 32'(nNMI), 32'h0);
    bus_idle(); tick();

    // Command arriving on the same edge as the acknowledge read
    CMD_DATA = 8'h22; CMD_WR = 1'b1;
    io_rd_start(16'h0000);
    check_val("sim_old", 32'(IO_DIN), 32'h11);
    tick();
    CMD_WR = 1'b0;
    #1;
    check_val("sim_new", 32'(IO_DIN), 32'h22);
    tick(); tick();
    check_val("sim_nnmi", 32'(nNMI), 32'h0);
    bus_idle(); tick();

    // Repeated commands overwrite; then acknowledge
    send_cmd(8'h33);
    send_cmd(8'h44);
    io_rd_start(16'h00E0);                 // mirror of port $00
    check_val("rep_44", 32'(IO_DIN), 32'h44);
    tick(); tick();
    check_val("rep_ack", 32'(nNMI), 32'h1);
    bus_idle(); tick();

    // Acknowledge by write of port $00
    send_cmd(8'h55);
    tick();
    check_val("w00_low", 32'(nNMI), 32'h0);
    io_access(16'h0000, 8'h00, 1'b1, 1);
    check_val("w00_ack", 32'(nNMI), 32'h1);

    // Reply written once per access
    io_wr_start(16'h000C, 8'h5A);
    tick();
    check_val("reply_5a", 32'(REPLY), 32'h5A);
    SDD_OUT = 8'h77;
    tick(); tick();
    check_val("reply_once", 32'(REPLY), 32'h5A);
    bus_idle(); tick();
    io_access(16'h00EC, 8'hC3, 1'b1, 1);
    check_val("reply_mirror", 32'(REPLY), 32'hC3);

    // YM2610 select
    io_wr_start(16'h0006, 8'h00);
    check_val("ym_wr_cs", 32'(nYM_CS), 32'h0);
    check_val("ym_wr_a", 32'(YM_A), 32'h2);
    bus_idle();
    #1;
    check_val("ym_off", 32'(nYM_CS), 32'h1);
    io_rd_start(16'h00A5);
    check_val("ym_rd_cs", 32'(nYM_CS), 32'h0);
    check_val("ym_rd_a", 32'(YM_A), 32'h1);
    bus_idle();
    #1;
    io_rd_start(16'h0008);
    check_val("ym_not8", 32'(nYM_CS), 32'h1);
    bus_idle();
    tick();

    // Reset asserted mid-access
    send_cmd(8'h66);
    tick();
    check_val("pre_rst_nnmi", 32'(nNMI), 32'h0);
    nRESET = 1'b0;
    io_rd_start(16'h4209);
    tick();
    nRESET = 1'b1;
    tick(); tick();
    bus_idle();
    SDA = 16'h0000;
    #1;
    check_val("mr_reply", 32'(REPLY), 32'h00);
    check_val("mr_nmien", 32'(NMI_EN), 32'h0);
    check_val("mr_nnmi", 32'(nNMI), 32'h1);
    check_val("mr_latch", 32'(IO_DIN), 32'h00);
    mem_check("mr_E456", 16'hE456, 22'h00E456, 1'b0, 1'b1);
    mem_check("mr_8000", 16'h8000, 22'h008000, 1'b0, 1'b1);
    mem_check("mr_C123", 16'hC123, 22'h00C123, 1'b0, 1'b1);
    mem_check("mr_F789", 16'hF789, 22'h00F789, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/z80_sysctrl.md
# z80_sysctrl

Sound-side system controller for the Z80. It decodes the Z80's registered bus strobes into the 68k↔Z80 command/reply mailbox, NMI request logic, the four Z80 ROM bank registers and the YM2610 chip select. It also generates the banked Z80 ROM address and the memory selects. It sits between the Z80 CPU wrapper, the sound ROM/RAM and the 68k-side latch interface. All logic is in the CLK_4M domain.

## Interface
Parameters: none.

Ports:
- CLK_4M  in  1  clock; sole clock.
- nRESET  in  1  reset, synchronous, active-low; clock CLK_4M.
- SDA  in  16  Z80 address bus.
- SDD_OUT  in  8  Z80 write data.
- nIORQ, nMREQ, nRD, nWR  in  1 each  Z80 strobes. Registered; each access is low for ≥1 cycle.
- CMD_WR  in  1  single-cycle pulse, already synchronised to CLK_4M: 68k writes a sound command.
- CMD_DATA  in  8  sound command value, valid with CMD_WR.
- REPLY  out  8  last reply byte written by the Z80.
- IO_DIN  out  8  data for Z80 I/O reads.
- nNMI  out  1  Z80 NMI request, active-low.
- NMI_EN  out  1  NMI enable status.
- ROM_ADDR  out  22  banked Z80 ROM byte address.
- nROM_CS, nRAM_CS  out  1  memory selects, active-low.
- nYM_CS  out  1  YM2610 select, active-low.
- YM_A  out  2  YM2610 register address.

## Operation
- **Access detection:**
  - io_rd = ~nIORQ & ~nRD; io_wr = ~nIORQ & ~nWR.
  - An access acts once, on its first low cycle. Use prev-cycle edge detect so a multi-cycle strobe does not retrigger.
- **Port decode:** SDA[4:0] only; SDA[7:5] mirror.
  - Read $00: IO_DIN = command latch; clears nmi_pend.
  - Write $00: clears nmi_pend.
  - $04–$07 (read or write): nYM_CS low while strobe active; YM_A = SDA[1:0]. Combinational.
  - Write $08: NMI_EN←1. Write $18: NMI_EN←0.
  - Write $0C: REPLY←SDD_OUT.
  - Read $08/$09/$0A/$0B: bank2k/bank4k/bank8k/bank16k ← SDA[15:8].
  - All other reads: IO_DIN = 8'hFF.
- **Command latch:**
  - CMD_WR loads the latch from CMD_DATA and sets nmi_pend.
  - nNMI = ~(nmi_pend & NMI_EN), registered.
- **ROM mapping:** combinational from SDA and the bank registers; valid while ~nMREQ.
  - 0000–7FFF: ROM_ADDR = {7'b0, SDA[14:0]}.
  - 8000–BFFF: {bank16k, SDA[13:0]}.
  - C000–DFFF: {1'b0, bank8k, SDA[12:0]}.
  - E000–EFFF: {2'b0, bank4k, SDA[11:0]}.
  - F000–F7FF: {3'b0, bank2k, SDA[10:0]}.
  - nROM_CS low for ~nMREQ & SDA < F800. nRAM_CS low for ~nMREQ & SDA ≥ F800. Both are high when nMREQ is high.
  - F800–FFFF: ROM_ADDR = {11'b0, SDA[10:0]} (RAM offset).

## Timing
- **Reset values** (nRESET low at CLK_4M edge): command latch 0, REPLY 0, nmi_pend 0, NMI_EN 0, nNMI 1, bank16k 8'h02, bank8k 8'h06, bank4k 8'h0E, bank2k 8'h1E. These banks give a linear map at reset.
- **Reset priority:** reset overrides all other events, including mid-access. After release, a strobe that is already low is not treated as a new access.
- **Latency:**
  - Register updates are visible the cycle after the detecting edge.
  - nNMI falls 2 cycles after CMD_WR when NMI_EN=1: pend set, then registered output.
  - nNMI rises 2 cycles after the clearing access.
- **Pending while disabled:** if NMI_EN=0, nmi_pend is retained. Enabling later drives nNMI low 2 cycles after the $08 write.
- **Simultaneous events:**
  - CMD_WR in the same cycle as a clearing read/write of $00: set wins. The latch takes the new data and nmi_pend stays 1.
  - Read $00 returns the latch value before that same-cycle update.
- **Repeated commands:** a second CMD_WR before the Z80 reads $00 overwrites the latch; nmi_pend stays 1 (no queue).
- **Combinational outputs:** IO_DIN, nYM_CS, YM_A, ROM_ADDR and the selects respond combinationally to the current bus, with no cycle delay.

## Test plan
- Reset, then memory reads at 8000, C123, E456, F789 → ROM_ADDR 0x008000, 0x00C123, 0x00E456, 0x00F789; nROM_CS low.
- I/O read at address $350B → bank16k=0x35; memory read 8001 → ROM_ADDR 0x0D4001. I/O read $7F08 → bank2k=0x7F; read F010 → 0x03F810.
- Write $08, then CMD_WR data 0xA5 → nNMI low 2 cycles later. I/O read $00 → IO_DIN 0xA5; nNMI high 2 cycles later.
- NMI_EN=0 (write $18), CMD_WR 0x11 → nNMI stays high. Write $08 → nNMI low after 2 cycles.
- CMD_WR 0x22 in the same cycle as the Z80 $00 read edge → IO_DIN shows the old value, latch becomes 0x22, nNMI remains/goes low.
- Write $0C with data 0x5A held 3 cycles → REPLY=0x5A, written once. Access $06 → nYM_CS low, YM_A=2. Assert nRESET mid-access → all reset values restored.
